// File: rtl/i2c_codec_target.sv
// WM8731-style write-only I2C target: ACKs 2-byte register writes and holds them in a peekable register file.
// Optional build macro I2C_TGT_GLITCH_FILTER_EN adds a 3-sample majority filter on SCL/SDA.
module i2c_codec_target #(
    parameter logic [6:0] DEV_ADDR  = 7'h1A,
    parameter int         NUM_REGS  = 10,
    parameter logic [6:0] RESET_REG = 7'h0F
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oe,
    output logic       o_wr_valid,
    output logic [6:0] o_wr_addr,
    output logic [8:0] o_wr_data,
    input  logic [6:0] i_rd_addr,
    output logic [8:0] o_rd_data,
    output logic       o_err,
    output logic       o_busy
);

    localparam int         IDXW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [6:0] NREGS7 = 7'(NUM_REGS);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_BYTE1, S_ACK1, S_BYTE2, S_ACK2, S_EXTRA, S_IGNORE
    } state_t;

    state_t     state;
    logic [1:0] scl_sync, sda_sync;
    logic       scl_f, sda_f, scl_q, sda_q;
    logic [2:0] cnt;
    logic [7:0] shreg;
    logic [7:0] byte_next;
    logic       ack_on;
    logic [6:0] reg_addr;
    logic [8:0] data;
    logic [8:0] regs [NUM_REGS];
    logic       scl_rise, scl_fall, start_det, stop_det;

    // Bus idles high, so synchronizers reset to 1 to avoid a phantom START after reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], i_scl};
            sda_sync <= {sda_sync[0], i_sda};
        end
    end

`ifdef I2C_TGT_GLITCH_FILTER_EN
    logic [2:0] scl_hist, sda_hist;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            scl_hist <= 3'b111;
            sda_hist <= 3'b111;
        end else begin
            scl_hist <= {scl_hist[1:0], scl_sync[1]};
            sda_hist <= {sda_hist[1:0], sda_sync[1]};
        end
    end

    assign scl_f = (scl_hist[0] & scl_hist[1]) | (scl_hist[0] & scl_hist[2]) | (scl_hist[1] & scl_hist[2]);
    assign sda_f = (sda_hist[0] & sda_hist[1]) | (sda_hist[0] & sda_hist[2]) | (sda_hist[1] & sda_hist[2]);
`else
    assign scl_f = scl_sync[1];
    assign sda_f = sda_sync[1];
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_f;
            sda_q <= sda_f;
        end
    end

    assign scl_rise  = scl_f & ~scl_q;
    assign scl_fall  = ~scl_f & scl_q;
    assign start_det = scl_f & scl_q & sda_q & ~sda_f;
    assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;
    assign byte_next = {shreg[6:0], sda_f};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            shreg      <= '0;
            ack_on     <= 1'b0;
            reg_addr   <= '0;
            data       <= '0;
            o_sda_oe   <= 1'b0;
            o_wr_valid <= 1'b0;
            o_wr_addr  <= '0;
            o_wr_data  <= '0;
            o_err      <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            o_wr_valid <= 1'b0;
            o_err      <= 1'b0;
            if (start_det) begin
                state    <= S_ADDR;
                cnt      <= '0;
                ack_on   <= 1'b0;
                o_sda_oe <= 1'b0;
            end else if (stop_det) begin
                // A write cut short by STOP is a protocol error; nothing is stored.
                if (state inside {S_BYTE1, S_ACK1, S_BYTE2}) o_err <= 1'b1;
                state    <= S_IDLE;
                ack_on   <= 1'b0;
                o_sda_oe <= 1'b0;
            end else begin
                case (state)
                    S_ADDR, S_BYTE1, S_BYTE2, S_EXTRA: begin
                        if (scl_rise) begin
                            shreg <= byte_next;
                            cnt   <= cnt + 3'd1;
                            if (cnt == 3'd7) begin
                                case (state)
                                    S_ADDR: begin
                                        if (byte_next[7:1] == DEV_ADDR && !byte_next[0]) begin
                                            state <= S_ADDR_ACK;
                                        end else begin
                                            state <= S_IGNORE;
                                            if (byte_next[7:1] == DEV_ADDR) o_err <= 1'b1;
                                        end
                                    end
                                    S_BYTE1: begin
                                        reg_addr <= byte_next[7:1];
                                        data[8]  <= byte_next[0];
                                        state    <= S_ACK1;
                                    end
                                    S_BYTE2: begin
                                        data[7:0] <= byte_next;
                                        state     <= S_ACK2;
                                    end
                                    default: begin
                                        o_err <= 1'b1;
                                        state <= S_IGNORE;
                                    end
                                endcase
                            end
                        end
                    end
                    S_ADDR_ACK, S_ACK1, S_ACK2: begin
                        // First SCL fall after bit 8 pulls SDA low, the next one releases it and moves on.
                        if (scl_fall) begin
                            if (!ack_on) begin
                                ack_on   <= 1'b1;
                                o_sda_oe <= 1'b1;
                            end else begin
                                ack_on   <= 1'b0;
                                o_sda_oe <= 1'b0;
                                cnt      <= '0;
                                case (state)
                                    S_ADDR_ACK: state <= S_BYTE1;
                                    S_ACK1:     state <= S_BYTE2;
                                    default: begin
                                        state      <= S_EXTRA;
                                        o_wr_valid <= 1'b1;
                                        o_wr_addr  <= reg_addr;
                                        o_wr_data  <= data;
                                        if (reg_addr == RESET_REG) begin
                                            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
                                        end else if (reg_addr < NREGS7) begin
                                            regs[reg_addr[IDXW-1:0]] <= data;
                                        end else begin
                                            o_err <= 1'b1;
                                        end
                                    end
                                endcase
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_rd_data = (i_rd_addr < NREGS7) ? regs[i_rd_addr[IDXW-1:0]] : 9'd0;
    assign o_busy    = (state != S_IDLE);

endmodule

// File: tb/tb_i2c_codec_target.sv
// Directed bench for i2c_codec_target: a bus master drives WM8731 writes, a transaction-level model predicts ACKs, writes, errors and register contents.
module tb_i2c_codec_target;

    localparam int H = 20;  // SCL half period in i_clk cycles

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       bus_sda;
    logic       o_sda_oe, o_wr_valid, o_err, o_busy;
    logic [6:0] o_wr_addr;
    logic [8:0] o_wr_data, o_rd_data;
    logic [6:0] i_rd_addr = '0;

    int tests = 0, fails = 0;
    int wr_cnt = 0, err_cnt = 0;
    logic [8:0] mregs [10];
    bit   model_busy = 1'b0;
    bit   settled = 1'b0;

    assign bus_sda = sda_m & ~o_sda_oe;

    always #5 clk = ~clk;

    i2c_codec_target dut (
        .i_clk(clk), .i_rst(rst), .i_scl(scl_m), .i_sda(bus_sda),
        .o_sda_oe(o_sda_oe), .o_wr_valid(o_wr_valid), .o_wr_addr(o_wr_addr),
        .o_wr_data(o_wr_data), .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data),
        .o_err(o_err), .o_busy(o_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] exp_rd(input logic [6:0] a);
        return (a < 7'd10) ? mregs[a[3:0]] : 9'd0;
    endfunction

    task automatic model_write(input logic [6:0] a, input logic [8:0] d);
        if (a == 7'h0F) begin
            for (int i = 0; i < 10; i++) mregs[i] = '0;
        end else if (a < 7'd10) begin
            mregs[a[3:0]] = d;
        end
    endtask

    // Pulse counters and per-cycle checks of the settled state.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_wr_valid) wr_cnt++;
            if (o_err) err_cnt++;
        end
        if (settled) begin
            chk($sformatf("rd_data[%0d]", i_rd_addr), 32'(o_rd_data), 32'(exp_rd(i_rd_addr)));
            chk("busy", 32'(o_busy), 32'(model_busy));
            chk("sda_oe_idle", 32'(o_sda_oe), 32'd0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic settle();
        tick(8);
        settled = 1'b1;
        for (int a = 0; a < 16; a++) begin
            i_rd_addr = 7'(a);
            tick(1);
        end
        settled = 1'b0;
    endtask

    task automatic start_cond();
        sda_m = 1'b1; tick(H);
        scl_m = 1'b1; tick(H);
        sda_m = 1'b0; tick(H);
        scl_m = 1'b0; tick(4);
    endtask

    task automatic stop_cond();
        sda_m = 1'b0; tick(H);
        scl_m = 1'b1; tick(H);
        sda_m = 1'b1; tick(H);
    endtask

    task automatic send_byte(input logic [7:0] b, output bit acked);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; tick(H);
            scl_m = 1'b1; tick(H / 2);
            chk("sda_oe_data_bit", 32'(o_sda_oe), 32'd0);
            tick(H / 2);
            scl_m = 1'b0; tick(4);
        end
        sda_m = 1'b1; tick(H);
        scl_m = 1'b1; tick(H / 2);
        acked = o_sda_oe;
        tick(H / 2);
        scl_m = 1'b0; tick(4);
    endtask

    // Bytes are taken from the MSB end of 'bytes'; the model works purely on byte positions.
    task automatic do_txn(input logic [31:0] bytes, input int n, input bit end_stop);
        logic [7:0] b0, b;
        logic [6:0] wa;
        logic [8:0] wd;
        bit acked, exp_ack;
        int wr0, er0, exp_wr, exp_er;
        b0  = bytes[31:24];
        wa  = bytes[23:17];
        wd  = {bytes[16], bytes[15:8]};
        wr0 = wr_cnt;
        er0 = err_cnt;
        start_cond();
        model_busy = 1'b1;
        for (int i = 0; i < n; i++) begin
            b = bytes[31 - 8 * i -: 8];
            send_byte(b, acked);
            exp_ack = (b0 == 8'h34) && (i < 3);
            chk($sformatf("ack_byte%0d", i), 32'(acked), 32'(exp_ack));
        end
        exp_wr = (b0 == 8'h34 && n >= 3) ? 1 : 0;
        exp_er = (b0[7:1] == 7'h1A && b0[0]) ? 1 : 0;
        if (b0 == 8'h34) begin
            if (n >= 4) exp_er++;
            if (n >= 3 && wa != 7'h0F && wa >= 7'd10) exp_er++;
            if (end_stop && (n == 1 || n == 2)) exp_er++;
        end
        if (end_stop) begin
            stop_cond();
            model_busy = 1'b0;
        end
        tick(10);
        chk("wr_count", 32'(wr_cnt - wr0), 32'(exp_wr));
        chk("err_count", 32'(err_cnt - er0), 32'(exp_er));
        if (exp_wr != 0) begin
            chk("wr_addr", 32'(o_wr_addr), 32'(wa));
            chk("wr_data", 32'(o_wr_data), 32'(wd));
            model_write(wa, wd);
        end
        settle();
    endtask

    initial begin
        for (int i = 0; i < 10; i++) mregs[i] = '0;
        tick(3);
        chk("rst_sda_oe", 32'(o_sda_oe), 32'd0);
        chk("rst_wr_valid", 32'(o_wr_valid), 32'd0);
        chk("rst_wr_addr", 32'(o_wr_addr), 32'd0);
        chk("rst_wr_data", 32'(o_wr_data), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        rst = 1'b0;
        tick(5);
        settle();

        // Plain write reg 4 = 0x015, with literal pins.
        do_txn({8'h34, 8'h08, 8'h15, 8'h00}, 3, 1'b1);
        chk("lit_wr_addr", 32'(o_wr_addr), 32'h04);
        chk("lit_wr_data", 32'(o_wr_data), 32'h015);
        i_rd_addr = 7'd4; tick(1);
        chk("lit_rd4", 32'(o_rd_data), 32'h015);

        // reg 7, out-of-range address 0x10, then register-file reset via address 0x0F.
        do_txn({8'h34, 8'h0E, 8'h07, 8'h00}, 3, 1'b1);
        do_txn({8'h34, 8'h20, 8'h55, 8'h00}, 3, 1'b1);
        do_txn({8'h34, 8'h1E, 8'h00, 8'h00}, 3, 1'b1);
        i_rd_addr = 7'd7; tick(1);
        chk("lit_rd7_cleared", 32'(o_rd_data), 32'd0);

        // Wrong device address.
        do_txn({8'h36, 8'h08, 8'h15, 8'h00}, 3, 1'b1);

        // Read request waits in IGNORE until STOP.
        do_txn({8'h35, 24'h0}, 1, 1'b0);
        stop_cond();
        model_busy = 1'b0;
        settle();

        // STOP mid-write, open 2-byte write, then repeated START write.
        do_txn({8'h34, 8'h0C, 16'h0}, 2, 1'b1);
        do_txn({8'h34, 8'h0C, 16'h0}, 2, 1'b0);
        do_txn({8'h34, 8'h0C, 8'h9F, 8'h00}, 3, 1'b1);
        chk("lit_rs_addr", 32'(o_wr_addr), 32'h06);
        chk("lit_rs_data", 32'(o_wr_data), 32'h09F);

        // Write to the last register followed by an extra byte.
        do_txn({8'h34, 8'h12, 8'h01, 8'hAA}, 4, 1'b0);
        chk("lit_last_addr", 32'(o_wr_addr), 32'h09);
        chk("lit_last_data", 32'(o_wr_data), 32'h001);

        // Reset in the middle of an address byte.
        start_cond();
        for (int i = 0; i < 4; i++) begin
            sda_m = 1'b0; tick(H);
            scl_m = 1'b1; tick(H);
            scl_m = 1'b0; tick(4);
        end
        i_rd_addr = 7'd9;
        scl_m = 1'b1; tick(H / 2);
        chk("pre_rst_busy", 32'(o_busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_sda_oe", 32'(o_sda_oe), 32'd0);
        chk("mid_rst_wr_valid", 32'(o_wr_valid), 32'd0);
        chk("mid_rst_wr_addr", 32'(o_wr_addr), 32'd0);
        chk("mid_rst_wr_data", 32'(o_wr_data), 32'd0);
        chk("mid_rst_err", 32'(o_err), 32'd0);
        chk("mid_rst_busy", 32'(o_busy), 32'd0);
        chk("mid_rst_rd9", 32'(o_rd_data), 32'd0);
        for (int i = 0; i < 10; i++) mregs[i] = '0;
        model_busy = 1'b0;
        sda_m = 1'b1;
        tick(4);
        rst = 1'b0;
        settle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
